pipe_stage_buf: RTL

- Parametrised pipeline boundary register for the stream CPU.
- Carries LANES payload words per beat, for example PC plus instruction, with a valid/ready handshake.
- Supports flush (branch redirect) and counts squashed beats.
- MODE selects one of two buffer types:
  - MODE 0: single-entry register with a combinational ready path.
  - MODE 1: two-entry skid buffer with a registered ready that breaks the timing path.

---
 rtl/pipe_stage_buf_if.sv | 23 ++
 rtl/pipe_stage_buf.sv | 100 ++++++++++
 2 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream bundle for pipe_stage_buf: upstream beat in, head beat out.
// master drives the stream into the stage and consumes its output; slave is the stage.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline boundary register: single entry (MODE 0) or two-entry skid buffer (MODE 1),
// with synchronous flush and a saturating count of squashed beats.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int unsigned W = LANES * DATA_W;

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             in_ready, accept, emit;
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;

  // MODE 0 never reaches StTwo, so both modes share one state machine.
  assign in_ready  = (MODE == 0) ? (bus.out_ready || (state_q == StEmpty)) : in_ready_q;
  assign accept    = bus.in_valid && in_ready;
  assign emit      = (state_q != StEmpty) && bus.out_ready;
  assign occupancy = state_q;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = main_q;
  assign drop_cnt      = drop_q;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drop_inc = 2'd0;
    if (flush) begin
      state_d  = StEmpty;
      main_d   = '0;
      skid_d   = '0;
      // A beat leaving on this edge was delivered; only unsent holds and the new beat drop.
      drop_inc = occupancy - {1'b0, emit} + {1'b0, accept};
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = bus.in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            main_d = bus.in_data;
          end else if (accept) begin
            skid_d  = bus.in_data;
            state_d = StTwo;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    in_ready_d = (state_d != StTwo);

    drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      drop_q     <= drop_d;
    end
  end
endmodule
